cpu_trace_buffer: RTL

- Upstream of the simulation perf/trace monitor. Captures one trace record per executed Hack CPU instruction into a circular history buffer: PC, instruction word, memory-write flag, write address and write data.
- Stops capture a fixed number of instructions after the PC reaches FINAL_PC.
- Drains the frozen history oldest-first over a valid/ready interface to the downstream disassembler/logger.
- Gives a post-mortem window of the last DEPTH instructions before end-of-program.

---
 rtl/cpu_trace_buffer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cpu_trace_buffer.sv
// Circular trace history of executed Hack CPU instructions, frozen a fixed number of records
// after the PC reaches FINAL_PC and then drained oldest-first over a valid/ready port.
module cpu_trace_buffer #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [15:0] FINAL_PC  = 16'd400,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic                     CLK_50,
  input  logic                     resetN,
  input  logic                     arm,
  input  logic [14:0]              pc,
  input  logic [15:0]              instruction,
  input  logic                     write_m,
  input  logic [14:0]              addr_m,
  input  logic [15:0]              out_m,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [14:0]              rd_pc,
  output logic [15:0]              rd_inst,
  output logic                     rd_wr,
  output logic [14:0]              rd_addr,
  output logic [15:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     finished
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] POST_LAST = AW'((POST_TRIG == 0) ? 0 : POST_TRIG - 1);

  typedef enum logic [2:0] {StIdle, StArmed, StPost, StDrain, StDone} state_e;

  state_e        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] post_cnt;
  logic [14:0]   last_pc;
  logic          last_pc_valid;
  logic [62:0]   mem [DEPTH];

  logic          capture;
  logic          trigger;
  logic          pop;
  logic [62:0]   head;

  // A record is taken only on the first cycle of each new pc, so CPU stalls collapse to one entry.
  always_comb begin
    capture  = ((state == StArmed) || (state == StPost)) && (!last_pc_valid || (pc != last_pc));
    trigger  = capture && (state == StArmed) && ({1'b0, pc} >= FINAL_PC);
    rd_valid = (state == StDrain) && (count != '0);
    pop      = rd_valid && rd_ready;
    head     = rd_valid ? mem[rd_ptr] : '0;
  end

  assign {rd_pc, rd_inst, rd_wr, rd_addr, rd_data} = head;

  always_ff @(posedge CLK_50) begin
    if (capture) begin
      mem[wr_ptr] <= {pc, instruction, write_m, addr_m, out_m};
    end
  end

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      state         <= StIdle;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      post_cnt      <= '0;
      count         <= '0;
      last_pc       <= '0;
      last_pc_valid <= 1'b0;
      busy          <= 1'b0;
      finished      <= 1'b0;
    end else begin
      case (state)
        StIdle, StDone: begin
          if (arm) begin
            state         <= StArmed;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            post_cnt      <= '0;
            count         <= '0;
            last_pc_valid <= 1'b0;
            busy          <= 1'b1;
            finished      <= 1'b0;
          end
        end
        StArmed, StPost: begin
          last_pc       <= pc;
          last_pc_valid <= 1'b1;
          if (capture) begin
            wr_ptr <= wr_ptr + 1'b1;
            // A full buffer overwrites its oldest record.
            if (count == FULL) begin
              rd_ptr <= rd_ptr + 1'b1;
            end else begin
              count <= count + 1'b1;
            end
            if (state == StArmed) begin
              if (trigger) begin
                post_cnt <= '0;
                if (POST_TRIG == 0) begin
                  state <= StDrain;
                  busy  <= 1'b0;
                end else begin
                  state <= StPost;
                end
              end
            end else begin
              post_cnt <= post_cnt + 1'b1;
              if (post_cnt == POST_LAST) begin
                state <= StDrain;
                busy  <= 1'b0;
              end
            end
          end
        end
        StDrain: begin
          if (count == '0) begin
            state    <= StDone;
            finished <= 1'b1;
          end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
            if (count == (AW + 1)'(1)) begin
              state    <= StDone;
              finished <= 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
